serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor: latches two unsigned operands on a start request, computes A − B one bit per clock (LSB first) with a single borrow flip-flop and half-subtractor-style logic, then presents the registered difference and final borrow with a one-cycle done pulse. It is the sequential, subtract-direction counterpart of the team's combinational adder cells, used where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE or DONE
- a  input  WIDTH  minuend, sampled on the accepting edge
- b  input  WIDTH  subtrahend, sampled on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: diff/borrow just updated
- diff  output  WIDTH  result (a − b) mod 2^WIDTH, held until next completion
- borrow  output  1  final borrow out (1 ⇔ a < b), held with diff
- d_bit  output  1  current serial difference bit, valid when bit_valid
- bit_valid  output  1  high in each RUN cycle producing a bit

## Operation
- Reset: state IDLE; busy, done, diff, borrow, d_bit, bit_valid all 0; internal shift registers, borrow flop, counter cleared.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: load a, b into shift registers, borrow flop ← 0, counter ← 0, → RUN. DONE without start → IDLE.
- RUN, per edge: with x=a_sr[0], y=b_sr[0], bin=borrow flop: d = x^y^bin; bout = (~x&y) | (~(x^y)&bin). d shifted into result register from MSB side; a_sr, b_sr shift right; borrow flop ← bout; counter++.
- After WIDTH-th bit: diff ← full result register, borrow ← final bout, → DONE.
- start while RUN: ignored, no effect on operands or progress.
- diff/borrow change only at completion; never show partial results.
- rst at any time (including mid-RUN): immediate return to reset values; partial result discarded.

## Timing
- Accepting edge E0. busy=1 from E0 through edge E0+WIDTH.
- Bit i (i=0..WIDTH-1) output on d_bit with bit_valid=1 in cycle after edge E0+i; registered at edge E0+1+i.
- At edge E0+WIDTH: diff, borrow updated; done=1 for exactly the following cycle; busy=0.
- Latency start-accept → done: WIDTH cycles. Throughput: one operation per WIDTH+1 cycles (back-to-back start in DONE accepted).
- done and busy never high together.

## Configuration
- SERIAL_SUB_ADD_MODE_EN defined: extra port mode input 1, sampled with operands at accept; mode=1 subtract as above, mode=0 add: d = x^y^cin, cout = (x&y)|((x^y)&cin); borrow port then reports final carry out; diff = (a + b) mod 2^WIDTH.
- Undefined: no mode port; subtract only.

## Test plan
- WIDTH=8, a=200, b=55, start 1 cycle → done exactly 8 cycles after accept; diff=145 (8'h91), borrow=0; d_bit sequence LSB-first 1,0,0,0,1,0,0,1.
- a=55, b=200 → diff=8'h6F (111), borrow=1; a=8'hA5, b=8'hA5 → diff=0, borrow=0.
- a=0, b=1 → borrow ripples all bits: diff=8'hFF, borrow=1.
- Start a=200,b=55; re-assert start with a=1,b=1 at bit 3 → ignored, result still 145/0; back-to-back start in DONE cycle accepted.
- Assert rst during bit 4 → next cycle all outputs 0, state IDLE; new start a=10,b=3 → diff=7, borrow=0.
- With SERIAL_SUB_ADD_MODE_EN, mode=0, a=200, b=100 → diff=8'h2C, borrow(carry)=1; mode=1 same operands → diff=100, borrow=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one borrow flop.
// Define SERIAL_SUB_ADD_MODE_EN to add a mode port selecting add (0) or subtract (1).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             d_bit,
    output logic             bit_valid
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bor_q, bor_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sub_q, sub_d;

    logic x, y, dc, bout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bor_q    <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            sub_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bor_q    <= bor_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
        end
    end

    // The same flop carries borrow (subtract) or carry (add).
    always_comb begin
        x    = a_q[0];
        y    = b_q[0];
        dc   = x ^ y ^ bor_q;
        bout = sub_q ? ((~x & y) | (~(x ^ y) & bor_q))
                     : ((x & y) | ((x ^ y) & bor_q));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bor_d    = bor_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    sub_d   = mode;
`else
                    sub_d   = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {dc, res_q[WIDTH-1:1]};
                bor_d = bout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    diff_d   = {dc, res_q[WIDTH-1:1]};
                    borrow_d = bout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign bit_valid = busy;
    assign d_bit     = busy & dc;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Mode tests run only when SERIAL_SUB_ADD_MODE_EN is defined.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic       mode = 1'b1;
`endif
    logic       busy, done, borrow, d_bit, bit_valid;
    logic [7:0] diff;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_d = '0;
    logic       prev_b = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .mode      (mode),
`endif
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow    (borrow),
        .d_bit     (d_bit),
        .bit_valid (bit_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi,
                          input logic [7:0] ed, input logic eb,
                          input int poke, input string tag);
        a = ai;
        b = bi;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == poke) begin
                start = 1'b1;
                a = 8'h01;
                b = 8'h01;
            end
            chk({tag, " d_bit"}, {31'd0, d_bit}, {31'd0, ed[i]});
            chk({tag, " bit_valid"}, {31'd0, bit_valid}, 32'd1);
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " done_low"}, {31'd0, done}, 32'd0);
            chk({tag, " diff_hold"}, {24'd0, diff}, {24'd0, prev_d});
            chk({tag, " borrow_hold"}, {31'd0, borrow}, {31'd0, prev_b});
            tick();
            start = 1'b0;
        end
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, " bv_low"}, {31'd0, bit_valid}, 32'd0);
        chk({tag, " diff"}, {24'd0, diff}, {24'd0, ed});
        chk({tag, " borrow"}, {31'd0, borrow}, {31'd0, eb});
        prev_d = ed;
        prev_b = eb;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst diff", {24'd0, diff}, 32'd0);
        chk("rst borrow", {31'd0, borrow}, 32'd0);
        chk("rst d_bit", {31'd0, d_bit}, 32'd0);
        chk("rst bit_valid", {31'd0, bit_valid}, 32'd0);

        run_op(8'd200, 8'd55, 8'h91, 1'b0, -1, "200-55");
        run_op(8'd55, 8'd200, 8'h6F, 1'b1, -1, "55-200 b2b");
        tick();
        chk("idle done", {31'd0, done}, 32'd0);
        chk("idle busy", {31'd0, busy}, 32'd0);
        chk("idle diff", {24'd0, diff}, 32'h6F);
        run_op(8'hA5, 8'hA5, 8'h00, 1'b0, -1, "A5-A5");
        tick();
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, -1, "0-1");
        tick();
        run_op(8'd200, 8'd55, 8'h91, 1'b0, 3, "ignore_start");
        tick();

        a = 8'd200;
        b = 8'd55;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid bit4", {31'd0, d_bit}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst busy", {31'd0, busy}, 32'd0);
        chk("mrst done", {31'd0, done}, 32'd0);
        chk("mrst diff", {24'd0, diff}, 32'd0);
        chk("mrst borrow", {31'd0, borrow}, 32'd0);
        chk("mrst d_bit", {31'd0, d_bit}, 32'd0);
        chk("mrst bit_valid", {31'd0, bit_valid}, 32'd0);
        prev_d = 8'h00;
        prev_b = 1'b0;
        tick();
        chk("mrst idle", {31'd0, busy}, 32'd0);
        run_op(8'd10, 8'd3, 8'd7, 1'b0, -1, "10-3");
        tick();

`ifdef SERIAL_SUB_ADD_MODE_EN
        mode = 1'b0;
        run_op(8'd200, 8'd100, 8'h2C, 1'b1, -1, "add 200+100");
        mode = 1'b1;
        run_op(8'd200, 8'd100, 8'd100, 1'b0, -1, "sub 200-100");
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
